// File: rtl/psg_tone_bank.sv
// SN76489-class sound generator: NUM_TONES square-wave channels plus one LFSR noise channel on channel index 3, driven by a byte-wide command bus.
// Define PSG_STEREO_EN to make the pan register writable; otherwise pan is fixed at 8'hFF.
module psg_tone_bank #(
  parameter int          NUM_TONES  = 3,
  parameter int          FREQ_W     = 10,
  parameter int          CLK_DIV    = 16,
  parameter int          NOISE_W    = 16,
  parameter logic [15:0] NOISE_TAP  = 16'h0009,
  parameter int          WRITE_WAIT = 32
) (
  input  logic                 clock_i,
  input  logic                 res_i,
  input  logic                 clock_en_i,
  input  logic                 ce_n_i,
  input  logic                 we_n_i,
  input  logic                 a_i,
  input  logic [7:0]           d_i,
  output logic                 ready_o,
  output logic [NUM_TONES-1:0] tone_o,
  output logic                 noise_o,
  output logic [5:0]           aout_o,
  output logic [5:0]           aout_l_o,
  output logic [5:0]           aout_r_o
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (WRITE_WAIT > 1) ? $clog2(WRITE_WAIT + 1) : 1;
  localparam logic [NOISE_W-1:0] LFSR_SEED = {1'b1, {(NOISE_W-1){1'b0}}};

  logic [PRE_W-1:0]   pre_cnt;
  logic               tick;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wr_acc;
  logic               cmd_wr;
  logic               is_latch;
  logic [1:0]         lat_ch;
  logic               lat_type;
  logic [1:0]         tgt_ch;
  logic               tgt_att;
  logic               ctrl_wr;
  logic [3:0]         att [4];
  logic [2:0]         noise_ctrl;
  logic [6:0]         noise_cnt;
  logic [6:0]         noise_reload;
  logic               noise_tgl;
  logic               noise_step;
  logic               noise_fb;
  logic               src_tgl;
  logic [NOISE_W-1:0] lfsr;
  logic [7:0]         pan;
  logic [3:0]         ch_out;
  logic [5:0]         sum_m;
  logic [5:0]         sum_l;
  logic [5:0]         sum_r;

  // Bus handshake: a byte is taken on any rising edge where ready_o=1, ce_n_i=0 and
  // we_n_i=0; ready_o then stays low for WRITE_WAIT cycles and strobes meanwhile are ignored.
  assign wr_acc   = ready_o && !ce_n_i && !we_n_i;
  assign cmd_wr   = wr_acc && !a_i;
  assign is_latch = d_i[7];
  assign tgt_ch   = is_latch ? d_i[6:5] : lat_ch;
  assign tgt_att  = is_latch ? d_i[4]   : lat_type;
  assign ctrl_wr  = cmd_wr && !tgt_att && (tgt_ch == 2'd3);

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      ready_o  <= 1'b1;
      wait_cnt <= '0;
    end else if (wr_acc && (WRITE_WAIT > 0)) begin
      ready_o  <= 1'b0;
      wait_cnt <= WAIT_W'(WRITE_WAIT - 1);
    end else if (!ready_o) begin
      if (wait_cnt == '0) ready_o <= 1'b1;
      else                wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      lat_ch   <= 2'd0;
      lat_type <= 1'b0;
    end else if (cmd_wr && is_latch) begin
      lat_ch   <= d_i[6:5];
      lat_type <= d_i[4];
    end
  end

  // Prescaler: one generator tick per CLK_DIV enabled clocks.
  assign tick = clock_en_i && (pre_cnt == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clock_i) begin
    if (res_i)           pre_cnt <= '0;
    else if (clock_en_i) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  // Attenuators; channels between NUM_TONES and 2 are never written.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      for (int c = 0; c < 4; c++) att[c] <= 4'hF;
    end else if (cmd_wr && tgt_att) begin
      for (int c = 0; c < 4; c++) begin
        if (((c < NUM_TONES) || (c == 3)) && (tgt_ch == 2'(c))) att[c] <= d_i[3:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_TONES; i++) begin : g_tone
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] cnt;
    logic              out;
    logic              hit;
    logic              wr_lo;
    logic              wr_hi;

    assign hit   = cmd_wr && !tgt_att && (tgt_ch == 2'(i));
    assign wr_lo = hit && is_latch;
    assign wr_hi = hit && !is_latch;

    // The counter is never reset by a write; a new freq lands at the next reload.
    always_ff @(posedge clock_i) begin
      if (res_i) begin
        freq <= '0;
        cnt  <= '0;
        out  <= 1'b1;
      end else begin
        if (tick) begin
          if (freq == '0) begin
            cnt <= '0;
            out <= 1'b1;
          end else if (cnt <= FREQ_W'(1)) begin
            cnt <= freq;
            out <= ~out;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        if (wr_lo) freq[3:0]        <= d_i[3:0];
        if (wr_hi) freq[FREQ_W-1:4] <= d_i[FREQ_W-5:0];
      end
    end

    assign tone_o[i] = out;

    if (i == NUM_TONES - 1) begin : g_src
      assign src_tgl = tick && (freq != '0) && (cnt <= FREQ_W'(1));
    end
  end

  always_comb begin
    noise_reload = 7'd64;
    case (noise_ctrl[1:0])
      2'b00:   noise_reload = 7'd16;
      2'b01:   noise_reload = 7'd32;
      default: noise_reload = 7'd64;
    endcase
  end

  assign noise_step = (noise_ctrl[1:0] == 2'b11) ? src_tgl
                                                 : (tick && (noise_cnt <= 7'd1));
  assign noise_fb   = noise_ctrl[2] ? ^(lfsr & NOISE_TAP[NOISE_W-1:0]) : lfsr[0];

  // The LFSR advances on each 0->1 edge of the internal noise square; a ctrl write reseeds it.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      noise_ctrl <= 3'd0;
      noise_cnt  <= '0;
      noise_tgl  <= 1'b1;
      lfsr       <= LFSR_SEED;
    end else begin
      if (tick && (noise_ctrl[1:0] != 2'b11)) begin
        noise_cnt <= (noise_cnt <= 7'd1) ? noise_reload : noise_cnt - 1'b1;
      end
      if (noise_step) begin
        noise_tgl <= ~noise_tgl;
        if (!noise_tgl) lfsr <= {noise_fb, lfsr[NOISE_W-1:1]};
      end
      if (ctrl_wr) begin
        noise_ctrl <= d_i[2:0];
        lfsr       <= LFSR_SEED;
      end
    end
  end

  assign noise_o = lfsr[0];

`ifdef PSG_STEREO_EN
  always_ff @(posedge clock_i) begin
    if (res_i)               pan <= 8'hFF;
    else if (wr_acc && a_i)  pan <= d_i;
  end
`else
  assign pan = 8'hFF;
`endif

  function automatic logic [5:0] level(input logic on, input logic [3:0] a);
    return on ? {2'b00, 4'hF - a} : 6'd0;
  endfunction

  always_comb begin
    ch_out                  = 4'd0;
    ch_out[NUM_TONES-1:0]   = tone_o;
    ch_out[3]               = noise_o;
  end

  always_comb begin
    sum_m = 6'd0;
    sum_l = 6'd0;
    sum_r = 6'd0;
    for (int c = 0; c < 4; c++) begin
      sum_m = sum_m + level(ch_out[c], att[c]);
      if (pan[c])     sum_r = sum_r + level(ch_out[c], att[c]);
      if (pan[c + 4]) sum_l = sum_l + level(ch_out[c], att[c]);
    end
  end

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      aout_o   <= 6'd0;
      aout_l_o <= 6'd0;
      aout_r_o <= 6'd0;
    end else begin
      aout_o   <= sum_m;
      aout_l_o <= sum_l;
      aout_r_o <= sum_r;
    end
  end

endmodule

// File: tb/tb_psg_tone_bank.sv
// Self-checking bench for psg_tone_bank: reset state, bus handshake, tone period, mix timing, white-noise sequence, reset mid-wait and pan.
module tb_psg_tone_bank;

  localparam int WAIT   = 32;
  localparam int TICK   = 16;
  localparam int PERIOD = 13 * TICK;
  localparam int SHIFT  = 2 * 16 * TICK;

  logic       clk = 1'b0;
  logic       res;
  logic       clk_en;
  logic       ce_n;
  logic       we_n;
  logic       a_sel;
  logic [7:0] d_bus;
  logic       ready;
  logic [2:0] tone;
  logic       noise;
  logic [5:0] aout;
  logic [5:0] aout_l;
  logic [5:0] aout_r;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psg_tone_bank dut (
    .clock_i    (clk),
    .res_i      (res),
    .clock_en_i (clk_en),
    .ce_n_i     (ce_n),
    .we_n_i     (we_n),
    .a_i        (a_sel),
    .d_i        (d_bus),
    .ready_o    (ready),
    .tone_o     (tone),
    .noise_o    (noise),
    .aout_o     (aout),
    .aout_l_o   (aout_l),
    .aout_r_o   (aout_r)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic bus_write(input logic a, input logic [7:0] d);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_ready", ready, 1);
    ce_n  = 1'b0;
    we_n  = 1'b0;
    a_sel = a;
    d_bus = d;
    @(negedge clk);
    ce_n  = 1'b1;
    we_n  = 1'b1;
  endtask

  task automatic measure_wait(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq(tag, n, WAIT);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, ready, 1);
    check_eq({tag, "_tone"}, tone, 3'b111);
    check_eq({tag, "_aout"}, aout, 0);
    check_eq({tag, "_aout_l"}, aout_l, 0);
    check_eq({tag, "_aout_r"}, aout_r, 0);
  endtask

  logic        prev;
  logic        first;
  int          n_edges;
  int          n;
  int          k0;
  int unsigned lim;
  int unsigned last_t;
  int unsigned w_t;
  int unsigned t0;
  logic [15:0] m;
  logic        mb;
  logic [5:0]  aout_max;

  initial begin
    res = 1'b1; clk_en = 1'b1; ce_n = 1'b1; we_n = 1'b1; a_sel = 1'b0; d_bus = 8'h00;
    repeat (4) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check_idle("rst");
    check_eq("rst_noise", noise, 0);
    repeat (1000) @(negedge clk);
    check_idle("idle");
    check_eq("idle_noise", noise, 0);

    // ch0 freq = 13 -> toggle every 13 ticks
    bus_write(1'b0, 8'h8D);
    measure_wait("wait_8d");
    bus_write(1'b0, 8'h00);
    measure_wait("wait_00");
    repeat (5) exp_q.push_back(PERIOD);
    prev = tone[0]; first = 1'b1; last_t = 0;
    lim = cyc + PERIOD * 8;
    while (exp_q.size() > 0 && cyc < lim) begin
      @(negedge clk);
      if (tone[0] != prev) begin
        prev = tone[0];
        if (!first) check_eq("tone_period", cyc - last_t, exp_q.pop_front());
        first = 1'b0;
        last_t = cyc;
      end
    end
    check_eq("tone_left", exp_q.size(), 0);
    exp_q.delete();

    // ch0 att = 0 -> aout follows tone one cycle late
    bus_write(1'b0, 8'h90);
    measure_wait("wait_90");
    prev = tone[0]; n_edges = 0;
    lim = cyc + PERIOD * 6;
    while (n_edges < 4 && cyc < lim) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check_eq("aout_l_mix", aout_l, exp_q[0]);
        check_eq("aout_r_mix", aout_r, exp_q[0]);
        check_eq("aout_mix", aout, exp_q.pop_front());
      end
      if (tone[0] != prev) begin
        check_eq("aout_late", aout, prev ? 15 : 0);
        prev = tone[0];
        exp_q.push_back(prev ? 15 : 0);
        n_edges++;
      end
    end
    @(negedge clk);
    if (exp_q.size() > 0) check_eq("aout_mix", aout, exp_q.pop_front());
    check_eq("aout_edges", n_edges, 4);

    // strobes held through the wait: only 8'h9F is taken
    ce_n = 1'b0; we_n = 1'b0; a_sel = 1'b0; d_bus = 8'h9F;
    @(negedge clk);
    check_eq("b2b_busy", ready, 0);
    d_bus = 8'h9A;
    repeat (9) @(negedge clk);
    ce_n = 1'b1; we_n = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("b2b_wait", n + 9, WAIT);
    aout_max = 6'd0;
    repeat (PERIOD * 3) begin
      @(negedge clk);
      if (aout > aout_max) aout_max = aout;
    end
    check_eq("b2b_att15", aout_max, 0);

    // white noise, rate 16: reseed to 16'h8000, one shift per 512 cycles
    bus_write(1'b0, 8'hE4);
    w_t = cyc;
    check_eq("noise_seed", noise, 0);
    m = 16'h8000; mb = 1'b0; k0 = -1;
    for (int k = 1; k <= 41; k++) begin
      m = {^(m & 16'h0009), m[15:1]};
      if (m[0] != mb) begin
        mb = m[0];
        if (k0 < 0) k0 = k;
        else exp_q.push_back((k - k0) * SHIFT);
      end
    end
    measure_wait("wait_e4");
    prev = noise; first = 1'b1; t0 = 0;
    while (cyc < w_t + 41 * SHIFT) begin
      @(negedge clk);
      if (noise != prev) begin
        prev = noise;
        if (first) begin
          first = 1'b0;
          t0 = cyc;
          check_eq("noise_first_lo", ((cyc - w_t) > (k0 - 1) * SHIFT) ? 1 : 0, 1);
          check_eq("noise_first_hi", ((cyc - w_t) <= k0 * SHIFT) ? 1 : 0, 1);
        end else if (exp_q.size() == 0) begin
          check_eq("noise_extra", cyc - t0, 0);
        end else begin
          check_eq("noise_edge", cyc - t0, exp_q.pop_front());
        end
      end
    end
    check_eq("noise_seen", first, 0);
    check_eq("noise_missing", exp_q.size(), 0);
    exp_q.delete();

    // pan write with ch0 audible
    bus_write(1'b0, 8'h90);
    measure_wait("wait_90b");
    bus_write(1'b1, 8'h01);
    measure_wait("wait_pan");
    n = 0; lim = cyc + PERIOD * 3;
    while (n < 2 && cyc < lim) begin
      @(negedge clk);
      n = tone[0] ? n + 1 : 0;
    end
    check_eq("pan_found", n, 2);
    check_eq("pan_aout", aout, 15);
    check_eq("pan_aout_r", aout_r, 15);
`ifdef PSG_STEREO_EN
    check_eq("pan_aout_l", aout_l, 0);
`else
    check_eq("pan_aout_l", aout_l, 15);
`endif

    // reset in the middle of a write wait
    bus_write(1'b0, 8'h8D);
    repeat (5) @(negedge clk);
    check_eq("busy_before_reset", ready, 0);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check_idle("midrst");
    repeat (PERIOD * 2) @(negedge clk);
    check_idle("midrst_att");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
